// File: rtl/tmod_responder.sv
// tmod bus responder: command FSM with one-cycle acknowledge,
// config registers and a prescaled temperature sampler with sticky alarm.
module tmod_responder #(
  parameter int WIDTH = 8,
  parameter int OPW = 3,
  parameter int PRESCALE = 16,
  parameter logic [WIDTH-1:0] DEF_FRQ = WIDTH'(1),
  parameter logic [WIDTH-1:0] DEF_HIGH = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] opnd,
  output logic             ready,
  output logic             valid,
  output logic [1:0]       status,
  input  logic [WIDTH-1:0] temp_in,
  output logic [WIDTH-1:0] temp_sample,
  output logic             sample_strobe,
  output logic             alarm,
  output logic [WIDTH-1:0] frq_reg,
  output logic [WIDTH-1:0] high_reg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  localparam logic [OPW-1:0] OP_NOOP  = OPW'(0);
  localparam logic [OPW-1:0] OP_RESET = OPW'(1);
  localparam logic [OPW-1:0] OP_FRQ   = OPW'(2);
  localparam logic [OPW-1:0] OP_HIGH  = OPW'(3);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [1:0]       r_state;
  logic             r_armed;
  logic [OPW-1:0]   r_op;
  logic [WIDTH-1:0] r_opnd;
  logic             r_valid;
  logic [1:0]       r_status;
  logic [WIDTH-1:0] r_frq;
  logic [WIDTH-1:0] r_high;
  logic             r_alarm;
  logic [WIDTH-1:0] r_sample;
  logic             r_strobe;
  logic [PW-1:0]    r_pcnt;
  logic [WIDTH-1:0] r_icnt;

  logic w_exec;
  logic w_rst_op;
  logic w_clr;
  logic w_tick;
  logic w_iwrap;
  logic w_sample;
  logic w_known;
  logic w_alarm_nxt;

  assign w_exec   = (r_state == S_EXEC);
  assign w_rst_op = w_exec && (r_op == OP_RESET);
  // RESET and SET_FRQ restart the sampler and swallow a coincident sample
  assign w_clr    = w_rst_op || (w_exec && (r_op == OP_FRQ));
  assign w_tick   = (r_pcnt == PMAX);
  assign w_iwrap  = (r_icnt == r_frq - WIDTH'(1));
  assign w_sample = (r_frq != '0) && w_tick && w_iwrap && !w_clr;
  assign w_known  = (r_op == OP_RESET) || (r_op == OP_FRQ) ||
                    (r_op == OP_HIGH);

  always_comb begin
    w_alarm_nxt = r_alarm;
    if (w_rst_op)
      w_alarm_nxt = 1'b0;
    else if (w_sample)
      w_alarm_nxt = r_alarm | (temp_in > r_high);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_armed  <= 1'b1;
      r_op     <= OP_NOOP;
      r_opnd   <= '0;
      r_valid  <= 1'b0;
      r_status <= 2'b00;
    end else begin
      unique case (1'b1)
        (r_state == S_IDLE): begin
          if (op == OP_NOOP) begin
            r_armed <= 1'b1;
          end else if (r_armed) begin
            r_op    <= op;
            r_opnd  <= opnd;
            r_state <= S_EXEC;
          end
        end
        (r_state == S_EXEC): begin
          r_valid  <= 1'b1;
          r_status <= !w_known ? 2'b01 :
                      (w_alarm_nxt ? 2'b10 : 2'b00);
          r_state  <= S_ACK;
        end
        (r_state == S_ACK): begin
          r_valid  <= 1'b0;
          r_status <= 2'b00;
          r_armed  <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frq  <= DEF_FRQ;
      r_high <= DEF_HIGH;
    end else if (w_exec) begin
      if (r_op == OP_RESET) begin
        r_frq  <= DEF_FRQ;
        r_high <= DEF_HIGH;
      end else if (r_op == OP_FRQ) begin
        r_frq <= r_opnd;
      end else if (r_op == OP_HIGH) begin
        r_high <= r_opnd;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pcnt   <= '0;
      r_icnt   <= '0;
      r_sample <= '0;
      r_strobe <= 1'b0;
      r_alarm  <= 1'b0;
    end else begin
      if (w_clr || (r_frq == '0)) begin
        r_pcnt <= '0;
        r_icnt <= '0;
      end else if (w_tick) begin
        r_pcnt <= '0;
        r_icnt <= w_iwrap ? '0 : r_icnt + WIDTH'(1);
      end else begin
        r_pcnt <= r_pcnt + PW'(1);
      end
      r_strobe <= w_sample;
      r_alarm  <= w_alarm_nxt;
      if (w_rst_op)
        r_sample <= '0;
      else if (w_sample)
        r_sample <= temp_in;
    end
  end

  assign ready         = (r_state == S_IDLE) && r_armed;
  assign valid         = r_valid;
  assign status        = r_status;
  assign temp_sample   = r_sample;
  assign sample_strobe = r_strobe;
  assign alarm         = r_alarm;
  assign frq_reg       = r_frq;
  assign high_reg      = r_high;

endmodule

// File: tb/tb_tmod_responder.sv
// Scoreboard bench for tmod_responder: directed ops, acks checked
// by a monitor against queued expectations, sampler timing checks.
module tb_tmod_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] op = 3'd0;
  logic [7:0] opnd = 8'd0;
  logic       ready;
  logic       valid;
  logic [1:0] status;
  logic [7:0] temp_in = 8'h20;
  logic [7:0] temp_sample;
  logic       sample_strobe;
  logic       alarm;
  logic [7:0] frq_reg;
  logic [7:0] high_reg;

  tmod_responder dut (
    .clk(clk), .reset(reset), .op(op), .opnd(opnd),
    .ready(ready), .valid(valid), .status(status),
    .temp_in(temp_in), .temp_sample(temp_sample),
    .sample_strobe(sample_strobe), .alarm(alarm),
    .frq_reg(frq_reg), .high_reg(high_reg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] st;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   n_strobe = 0;
  int   last_strobe = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (sample_strobe) begin
      n_strobe    <= n_strobe + 1;
      last_strobe <= cyc;
    end
    if (valid) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("ack_status", int'(status), int'(e.st));
        chk("ack_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic do_op(input logic [2:0] o, input logic [7:0] d,
                       input logic [1:0] st, input int hold,
                       output int n);
    exp_t e;
    chk("ready_pre", int'(ready), 1);
    op   = o;
    opnd = d;
    @(posedge clk); #1;
    n = cyc;
    chk("ready_accept", int'(ready), 0);
    e.st  = st;
    e.cyc = n + 1;
    q.push_back(e);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("ready_hold", int'(ready), 0);
    end
    op = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("ready_back", int'(ready), 1);
  endtask

  task automatic wait_strobe(input int bound);
    int s;
    s = n_strobe;
    for (int i = 0; i < bound && n_strobe == s; i++)
      @(posedge clk);
    #1;
    chk("strobe_seen", n_strobe, s + 1);
  endtask

  initial begin
    int n, m, e0, s;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", int'(ready), 1);
    chk("rst_valid", int'(valid), 0);
    chk("rst_frq", int'(frq_reg), 8'h01);
    chk("rst_high", int'(high_reg), 8'hFF);
    chk("rst_alarm", int'(alarm), 0);
    chk("rst_sample", int'(temp_sample), 0);
    reset = 1'b1;
    e0 = cyc;
    wait_strobe(40);
    chk("first_strobe_cyc", last_strobe, e0 + 16);
    chk("first_sample", int'(temp_sample), 8'h20);

    do_op(3'd3, 8'h30, 2'b00, 5, n);
    chk("high_set", int'(high_reg), 8'h30);
    chk("alarm_still0", int'(alarm), 0);

    do_op(3'd2, 8'd3, 2'b00, 0, n);
    chk("frq_set", int'(frq_reg), 8'd3);
    temp_in = 8'h31;
    wait_strobe(100);
    chk("frq3_strobe1", last_strobe, n + 1 + 48);
    chk("alarm_set", int'(alarm), 1);
    chk("sample_31", int'(temp_sample), 8'h31);
    temp_in = 8'h10;
    wait_strobe(100);
    chk("frq3_strobe2", last_strobe, n + 1 + 96);
    chk("alarm_sticky", int'(alarm), 1);
    chk("sample_10", int'(temp_sample), 8'h10);

    do_op(3'd3, 8'h40, 2'b10, 0, n);
    chk("high_40", int'(high_reg), 8'h40);

    do_op(3'd1, 8'h00, 2'b00, 0, n);
    chk("rop_alarm", int'(alarm), 0);
    chk("rop_frq", int'(frq_reg), 8'h01);
    chk("rop_high", int'(high_reg), 8'hFF);
    chk("rop_sample", int'(temp_sample), 0);

    do_op(3'd5, 8'h99, 2'b01, 0, n);
    chk("unk_frq", int'(frq_reg), 8'h01);
    chk("unk_high", int'(high_reg), 8'hFF);

    do_op(3'd2, 8'd0, 2'b00, 0, n);
    chk("frq_zero", int'(frq_reg), 0);
    s = n_strobe;
    repeat (200) @(posedge clk);
    #1;
    chk("no_strobe_frq0", n_strobe, s);

    do_op(3'd2, 8'd1, 2'b00, 0, n);
    while (cyc < n + 15) begin
      @(posedge clk); #1;
    end
    s = n_strobe;
    do_op(3'd2, 8'd2, 2'b00, 0, m);
    chk("coinc_accept", m, n + 16);
    while (cyc < m + 40) begin
      @(posedge clk); #1;
    end
    chk("coinc_strobes", n_strobe, s + 1);
    chk("coinc_restart", last_strobe, m + 33);

    chk("ready_pre_abort", int'(ready), 1);
    op   = 3'd2;
    opnd = 8'h07;
    @(posedge clk); #1;
    chk("abort_accept", int'(ready), 0);
    reset = 1'b0;
    #1;
    chk("abort_valid", int'(valid), 0);
    chk("abort_ready", int'(ready), 1);
    chk("abort_frq", int'(frq_reg), 8'h01);
    op = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_abort_ready", int'(ready), 1);
    chk("post_abort_frq", int'(frq_reg), 8'h01);
    chk("pending_acks", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tmod_responder.md
Name: tmod_responder

Overview:
- Monitor-side (responder) end of the tmod command bus.
- Accepts opcode/operand commands from the bus master and completes each with a one-cycle valid/status acknowledge.
- Holds the sample-frequency and high-temperature threshold registers.
- Periodically samples the temperature input and raises a sticky over-temperature alarm.

Parameters:
- WIDTH, 8, width of operand, temperature and threshold registers.
- OPW, 3, opcode width.
- PRESCALE, 16, clk cycles per sampler tick (≥1).
- DEF_FRQ, 8'd1, frq_reg value after reset or RESET op.
- DEF_HIGH, 8'hFF, high_reg value after reset or RESET op.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op  in  OPW  opcode. Encoding: NOOP=0, RESET=1, SET_FRQ=2, SET_HIGH_TEMP=3; all other codes are unknown.
- opnd  in  WIDTH  operand for SET_* ops.
- ready  out  1  responder idle and armed to accept an op.
- valid  out  1  one-cycle completion pulse.
- status  out  2  valid only while valid=1. 00 OK, 01 unknown op, 10 OK with alarm active.
- temp_in  in  WIDTH  unsigned temperature, sampled on sampler ticks.
- temp_sample  out  WIDTH  last sampled temperature.
- sample_strobe  out  1  one-cycle pulse when temp_sample updates.
- alarm  out  1  sticky; set when sample > high_reg.
- frq_reg, high_reg  out  WIDTH each  current configuration, visible for checking.

Behaviour:
- Reset (reset=0, async): state=IDLE, armed=1, ready=1, valid=0, status=00, alarm=0, sample_strobe=0, temp_sample=0, frq_reg=DEF_FRQ, high_reg=DEF_HIGH, prescale and interval counters=0.
- FSM states: IDLE, EXEC, ACK.
  - IDLE: ready=armed. On edge N with armed=1 and op≠NOOP: latch op/opnd, go to EXEC. ready=0 after edge N.
  - EXEC: at edge N+1, apply the latched op and go to ACK. valid=1 and status are driven after edge N+1.
  - ACK: at edge N+2, go to IDLE, valid=0, armed=0.
- Op completion latency: valid is high exactly one cycle, 2 edges after acceptance.
- Re-arm: in IDLE, armed is set by any edge sampling op==NOOP. A held non-NOOP op is never executed twice; ready stays 0 until the master returns op to NOOP.
- op/opnd are ignored in EXEC and ACK. Only the values latched at acceptance are used.
- SET_FRQ: frq_reg←opnd, and both counters clear.
- SET_HIGH_TEMP: high_reg←opnd. alarm is not re-evaluated until the next sample.
- RESET op: frq_reg, high_reg, alarm, counters and temp_sample return to their reset values. The FSM still completes ACK with status 00.
- Unknown op: no register changes; status=01.
- Status for RESET/SET_*: 10 if alarm=1 after the EXEC edge, else 00.
- Sampler:
  - The prescale counter counts 0..PRESCALE-1 and emits a tick on wrap.
  - The interval counter counts ticks 0..frq_reg-1.
  - On its wrap: temp_sample←temp_in, sample_strobe=1 for one cycle, alarm←alarm | (temp_in > high_reg), unsigned strict compare.
  - Sample period = frq_reg×PRESCALE clk cycles.
  - frq_reg=0: sampling disabled and counters held at 0.
- Simultaneous events at the EXEC edge:
  - RESET or SET_FRQ vs. sample: the op wins and the sample is discarded, no strobe.
  - SET_HIGH_TEMP vs. sample: the compare uses the old high_reg.
- alarm clears only on reset or the RESET op. temp_in ≤ high_reg never clears it.
- Async reset mid-op (EXEC/ACK): outputs go immediately to reset values. No valid pulse is emitted for the aborted op.

Test Plan:
- Reset release: ready=1, valid=0, frq_reg=1, high_reg=FF, alarm=0. With PRESCALE=16 and temp_in=0x20: first sample_strobe 16 cycles after reset, temp_sample=0x20.
- op=SET_HIGH_TEMP, opnd=0x30, accepted at edge N: ready=0 after N, valid=1/status=00 during N+1..N+2, high_reg=0x30. op held non-NOOP for 5 more cycles: no second valid, ready stays 0 until op=NOOP.
- SET_FRQ opnd=3, temp_in=0x31, high_reg=0x30: strobe every 48 cycles; alarm=1 on first strobe. temp_in→0x10: alarm stays 1. Next op then acks with status=10.
- op=RESET with alarm=1: alarm=0, frq_reg=1, high_reg=FF, temp_sample=0, status=00. op=5: status=01, registers unchanged.
- SET_FRQ opnd=0: no sample_strobe for 200 cycles. SET_FRQ on the same edge as a due sample: no strobe, counters restart.
- Assert reset=0 while in EXEC for SET_FRQ 0x07: no valid pulse, frq_reg=1, ready=1 after release.
